// File: rtl/alu_adder_pkg.sv
// Shared types and sizing helpers for the chunked ALU adder.
// The helpers let every instance derive its chunk count and counter width from WIDTH and CHUNK.
package alu_adder_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} add_state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int calc_count_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from fullAdder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            fullAdder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout     = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/fullAdder.sv
// One-bit full adder cell; the building block of the chunk ripple.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_alu_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB chunk first, with ARM NZCV flags.
// One chunk_adder is time-shared across all chunks through a registered carry.
module chunked_alu_adder
    import alu_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_count_w(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_alu_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    add_state_t       state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic             n_reg, z_reg, c_reg, v_reg;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
    logic             chunk_cout, chunk_c_msb;
    logic             last_chunk;
    logic [WIDTH-1:0] final_sum;

    assign base       = 32'(count_reg) * 32'(CHUNK);
    assign a_chunk    = a_reg[base +: CHUNK];
    assign b_chunk    = b_reg[base +: CHUNK];
    assign last_chunk = (count_reg == LAST);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .sum      (chunk_sum),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb),
        .a        (a_chunk),
        .b        (b_chunk),
        .cin      (carry_reg)
    );

    // Full result as it will look once the current chunk is written; flags use it on the last chunk.
    always_comb begin
        final_sum                    = sum_reg;
        final_sum[base +: CHUNK]     = chunk_sum;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = CALC;
            CALC:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            n_reg     <= 1'b0;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            v_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    // Subtraction is a + ~b + 1: invert b once and seed the carry.
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        count_reg <= '0;
                    end
                end
                CALC: begin
                    sum_reg   <= final_sum;
                    carry_reg <= chunk_cout;
                    count_reg <= count_reg + 1'b1;
                    if (last_chunk) begin
                        n_reg <= chunk_sum[CHUNK-1];
                        z_reg <= (final_sum == '0);
                        c_reg <= chunk_cout;
                        v_reg <= chunk_c_msb ^ chunk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign flag_n    = n_reg;
    assign flag_z    = z_reg;
    assign flag_c    = c_reg;
    assign flag_v    = v_reg;

endmodule
